// File: rtl/load_store_unit_if.sv
// CPU-side request/response and memory-controller bus for load_store_unit.
// slave = the unit itself; master = the environment (execute stage + memory).
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_fault;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_write_enable;
  logic [31:0]       mem_data_in;
  logic [31:0]       mem_data_out;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_data_out,
    output req_ready, resp_valid, resp_rdata, resp_fault,
           mem_addr, mem_write_enable, mem_data_in
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
           mem_addr, mem_write_enable, mem_data_in
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store sequencer between execute stage and memory_controller.
// Optional LSU_MISALIGNED_SPLIT_EN splits misaligned half/word accesses into byte accesses.
module load_store_unit #(
  parameter int          ADDR_W      = 32,
  parameter logic [31:0] FAULT_RDATA = 32'h0
) (
  input  logic             clk,
  input  logic             rst_n,
  load_store_unit_if.slave bus
);

`ifdef LSU_MISALIGNED_SPLIT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2, SPLIT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
`endif

  typedef struct packed {
    logic       write;
    logic [2:0] funct3;
  } req_t;

  state_t            state, state_nxt;
  req_t              r_req;
  logic              accept;
  logic              f3_ok, misal, fault_in;
  logic [2:0]        we_enc;
  logic [31:0]       ld_word;

  logic              resp_valid_q, resp_fault_q;
  logic [31:0]       resp_rdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [2:0]        mem_we_q;
  logic [31:0]       mem_data_in_q;

`ifdef LSU_MISALIGNED_SPLIT_EN
  logic              split_in;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       sp_data;
  logic [1:0]        cnt, r_last;
`endif

  assign accept = bus.req_valid && (state == IDLE);

  always_comb begin
    f3_ok = 1'b0;
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = !bus.req_write;
      default:                f3_ok = 1'b0;
    endcase
    misal = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
            ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    case (bus.req_funct3[1:0])
      2'b00:   we_enc = 3'b100;
      2'b01:   we_enc = 3'b010;
      default: we_enc = 3'b001;
    endcase
`ifdef LSU_MISALIGNED_SPLIT_EN
    fault_in = !f3_ok;
    split_in = f3_ok && misal;
`else
    fault_in = !f3_ok || misal;
`endif
  end

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  extend = {{24{d[7]}}, d[7:0]};
      3'b001:  extend = {{16{d[15]}}, d[15:0]};
      3'b100:  extend = {24'h0, d[7:0]};
      3'b101:  extend = {16'h0, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  // In SPLIT the current byte is merged into the partially assembled word
  always_comb begin
    ld_word = bus.mem_data_out;
`ifdef LSU_MISALIGNED_SPLIT_EN
    if (state == SPLIT) begin
      ld_word = sp_data;
      ld_word[{cnt, 3'b000} +: 8] = bus.mem_data_out[7:0];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) begin
        if (fault_in) state_nxt = RESP;
`ifdef LSU_MISALIGNED_SPLIT_EN
        else if (split_in) state_nxt = SPLIT;
`endif
        else state_nxt = ACCESS;
      end
      ACCESS: state_nxt = RESP;
      RESP:   state_nxt = IDLE;
`ifdef LSU_MISALIGNED_SPLIT_EN
      SPLIT:  if (cnt == r_last) state_nxt = RESP;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Memory-side outputs are registered so they are clean during ACCESS/SPLIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req         <= '0;
      resp_valid_q  <= 1'b0;
      resp_fault_q  <= 1'b0;
      resp_rdata_q  <= 32'h0;
      mem_addr_q    <= '0;
      mem_we_q      <= 3'b000;
      mem_data_in_q <= 32'h0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      r_addr        <= '0;
      r_wdata       <= 32'h0;
      sp_data       <= 32'h0;
      cnt           <= 2'd0;
      r_last        <= 2'd0;
`endif
    end else begin
      resp_valid_q <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          r_req <= '{write: bus.req_write, funct3: bus.req_funct3};
          if (fault_in) begin
            resp_valid_q <= 1'b1;
            resp_fault_q <= 1'b1;
            resp_rdata_q <= FAULT_RDATA;
          end else begin
            mem_addr_q    <= bus.req_addr;
            mem_data_in_q <= bus.req_wdata;
            mem_we_q      <= bus.req_write ? we_enc : 3'b000;
`ifdef LSU_MISALIGNED_SPLIT_EN
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            sp_data <= 32'h0;
            cnt     <= 2'd0;
            r_last  <= (bus.req_funct3[1:0] == 2'b01) ? 2'd1 : 2'd3;
            if (split_in) begin
              mem_data_in_q <= {24'h0, bus.req_wdata[7:0]};
              mem_we_q      <= bus.req_write ? 3'b100 : 3'b000;
            end
`endif
          end
        end
        ACCESS: begin
          mem_we_q     <= 3'b000;
          resp_valid_q <= 1'b1;
          resp_fault_q <= 1'b0;
          resp_rdata_q <= r_req.write ? 32'h0 : extend(r_req.funct3, ld_word);
        end
`ifdef LSU_MISALIGNED_SPLIT_EN
        SPLIT: begin
          sp_data <= ld_word;
          if (cnt == r_last) begin
            mem_we_q     <= 3'b000;
            resp_valid_q <= 1'b1;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= r_req.write ? 32'h0 : extend(r_req.funct3, ld_word);
          end else begin
            cnt           <= cnt + 2'd1;
            mem_addr_q    <= r_addr + ADDR_W'(cnt) + ADDR_W'(1);
            mem_data_in_q <= {24'h0, r_wdata[{cnt + 2'd1, 3'b000} +: 8]};
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.req_ready        = (state == IDLE);
  assign bus.resp_valid       = resp_valid_q;
  assign bus.resp_fault       = resp_fault_q;
  assign bus.resp_rdata       = resp_rdata_q;
  assign bus.mem_addr         = mem_addr_q;
  assign bus.mem_write_enable = mem_we_q;
  assign bus.mem_data_in      = mem_data_in_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: driver queues expected responses/writes,
// monitors compare whenever the unit emits resp_valid or a memory write.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(32)) bus ();

  load_store_unit #(.ADDR_W(32), .FAULT_RDATA(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          due;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  we;
    logic [31:0] data;
  } wr_t;

  exp_t sb[$];
  wr_t  wq[$];
  exp_t me;
  wr_t  mw;
  int   nvec = 0;
  int   nerr = 0;
  int   cyc  = 0;

`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam logic [31:0] SPL42_RD = 32'h4433_2211;
  localparam logic        SPL42_FL = 1'b0;
  localparam int          SPL42_LT = 5;
  localparam logic [31:0] SPL71_RD = 32'h0000_00AB;
  localparam logic        SPL71_FL = 1'b0;
  localparam int          SPL71_LT = 5;
`else
  localparam logic [31:0] SPL42_RD = 32'h0;
  localparam logic        SPL42_FL = 1'b1;
  localparam int          SPL42_LT = 1;
  localparam logic [31:0] SPL71_RD = 32'h0;
  localparam logic        SPL71_FL = 1'b1;
  localparam int          SPL71_LT = 1;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  // Byte-addressed memory model on the low 8 address bits
  logic [7:0] mem [256];
  logic       init_done = 1'b0;
  logic [7:0] ma;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h42] <= 8'h11; mem[8'h43] <= 8'h22; mem[8'h44] <= 8'h33; mem[8'h45] <= 8'h44;
      mem[8'h53] <= 8'h80;
      mem[8'h60] <= 8'h01; mem[8'h61] <= 8'h80;
      init_done <= 1'b1;
    end else begin
      ma = bus.mem_addr[7:0];
      case (bus.mem_write_enable)
        3'b001: begin
          mem[ma] <= bus.mem_data_in[7:0];            mem[ma + 8'd1] <= bus.mem_data_in[15:8];
          mem[ma + 8'd2] <= bus.mem_data_in[23:16];   mem[ma + 8'd3] <= bus.mem_data_in[31:24];
        end
        3'b010: begin
          mem[ma] <= bus.mem_data_in[7:0];            mem[ma + 8'd1] <= bus.mem_data_in[15:8];
        end
        3'b100: mem[ma] <= bus.mem_data_in[7:0];
        default: ;
      endcase
    end
  end

  logic [7:0] ra;
  always_comb begin
    ra = bus.mem_addr[7:0];
    bus.mem_data_out = {mem[ra + 8'd3], mem[ra + 8'd2], mem[ra + 8'd1], mem[ra]};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.resp_valid) begin
        if (sb.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL resp_unexpected: got rdata %h fault %0b, expected no response", bus.resp_rdata, bus.resp_fault);
        end else begin
          me = sb.pop_front();
          chk("resp_rdata", bus.resp_rdata, me.rdata);
          chk("resp_fault", {31'b0, bus.resp_fault}, {31'b0, me.fault});
          chk("resp_cycle", 32'(cyc), 32'(me.due));
        end
      end
      if (bus.mem_write_enable != 3'b000) begin
        if (wq.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL write_unexpected: got we %b addr %h, expected no write", bus.mem_write_enable, bus.mem_addr);
        end else begin
          mw = wq.pop_front();
          chk("wr_addr", bus.mem_addr, mw.addr);
          chk("wr_we", {29'b0, bus.mem_write_enable}, {29'b0, mw.we});
          chk("wr_data", bus.mem_data_in, mw.data);
        end
      end
    end
  end

  // Leaves req_valid high; the next request's fields are presented while the unit is busy
  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ef, input int lat, input logic [2:0] ewe);
    int n = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      nvec++; nerr++;
      $display("FAIL accept_timeout: req_ready stayed 0, expected 1 within 50 cycles");
    end else begin
      sb.push_back('{rdata: er, fault: ef, due: cyc + lat});
      if (ewe != 3'b000) wq.push_back('{addr: a, we: ewe, data: wd});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    bus.req_valid = 1'b0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      nvec++; nerr++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    #12;
    chk("rst_ready", {31'b0, bus.req_ready}, 32'h1);
    chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_resp_fault", {31'b0, bus.resp_fault}, 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_we", {29'b0, bus.mem_write_enable}, 32'h0);
    chk("rst_mem_data_in", bus.mem_data_in, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    issue(1'b0, 3'b010, 32'h1000_0042, 32'h0, SPL42_RD, SPL42_FL, SPL42_LT, 3'b000); drain();
    issue(1'b1, 3'b010, 32'h1000_0040, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 3'b001);       drain();
    issue(1'b0, 3'b010, 32'h1000_0040, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 3'b000);       drain();
    issue(1'b0, 3'b000, 32'h1000_0053, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 3'b000);       drain();
    issue(1'b0, 3'b100, 32'h1000_0053, 32'h0, 32'h0000_0080, 1'b0, 2, 3'b000);       drain();
    issue(1'b0, 3'b101, 32'h1000_0060, 32'h0, 32'h0000_8001, 1'b0, 2, 3'b000);       drain();
    issue(1'b0, 3'b001, 32'h1000_0060, 32'h0, 32'hFFFF_8001, 1'b0, 2, 3'b000);       drain();
    issue(1'b0, 3'b011, 32'h1000_0040, 32'h0, 32'h0, 1'b1, 1, 3'b000);               drain();
    issue(1'b1, 3'b100, 32'h1000_0040, 32'h5555_5555, 32'h0, 1'b1, 1, 3'b000);       drain();

    // Reset during the ACCESS cycle of a store
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h1000_0080; bus.req_wdata = 32'h1122_3344;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("mid_we_before_rst", {29'b0, bus.mem_write_enable}, 32'h1);
    chk("mid_ready_busy", {31'b0, bus.req_ready}, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("mid_we_after_rst", {29'b0, bus.mem_write_enable}, 32'h0);
    chk("mid_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_ready_release", {31'b0, bus.req_ready}, 32'h1);
    chk("mid_mem_addr", bus.mem_addr, 32'h0);
    repeat (3) @(negedge clk);
    chk("mid_no_store", {24'h0, mem[8'h80]}, 32'h0);

    // Back-to-back with req_valid held high
    issue(1'b1, 3'b001, 32'h1000_0070, 32'h1234_ABCD, 32'h0, 1'b0, 2, 3'b010);
    issue(1'b0, 3'b001, 32'h1000_0070, 32'h0, 32'hFFFF_ABCD, 1'b0, 2, 3'b000);
    issue(1'b0, 3'b010, 32'h1000_0071, 32'h0, SPL71_RD, SPL71_FL, SPL71_LT, 3'b000);
    drain();

    chk("sb_empty", 32'(sb.size()), 32'h0);
    chk("wq_empty", 32'(wq.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running at 200000, expected completion");
    $fatal(1);
  end

endmodule
